// File: rtl/pwm_wave_sequencer.sv
// PWM carrier sequencer: runs the carrier counter, steps a 2^CNT_W envelope and reloads duty per
// period. Optional feature macro: WAVE_TRIANGLE_EN enables the TRIANGLE (mode 3) envelope.
module pwm_wave_sequencer #(
  parameter int unsigned CNT_W    = 6,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       mode_req,
  input  logic             mode_valid,
  output logic             mode_ready,
  output logic [1:0]       active_mode,
  output logic [CNT_W-1:0] step_idx,
  output logic [CNT_W:0]   duty,
  output logic             period_tick,
  output logic             pulse
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StRun     = 2'd1;
  localparam logic [1:0] StPending = 2'd2;

  localparam logic [7:0]     PscMax = 8'(PRESCALE - 1);
  localparam logic [CNT_W:0] Full   = {1'b1, {CNT_W{1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       psc_q, psc_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic [1:0]       active_q, active_d;
  logic [1:0]       pend_q, pend_d;
  logic [CNT_W:0]   duty_q, duty_d;

  logic             running, xfer, wrap, step_adv, boundary;
  logic [CNT_W-1:0] step_next;

  // Envelope value for a mode at a given step; result is CNT_W+1 bits so 100 % is representable.
  function automatic logic [CNT_W:0] wave(input logic [1:0] m, input logic [CNT_W-1:0] s);
    logic [CNT_W:0] dbl;
    dbl  = {s, 1'b0};
    wave = '0;
    case (m)
      2'd1: wave = s[CNT_W-1] ? '0 : Full;
      2'd2: wave = {1'b0, s};
`ifdef WAVE_TRIANGLE_EN
      // Falling half: 2*(2^CNT_W - s) equals -2s modulo 2^(CNT_W+1).
      2'd3: wave = s[CNT_W-1] ? ('0 - dbl) : dbl;
`endif
      default: wave = '0;
    endcase
  endfunction

  assign running   = (state_q != StIdle);
  assign mode_ready = (state_q != StPending);
  assign xfer      = mode_valid & mode_ready;
  assign wrap      = running & (&cnt_q);
  assign step_adv  = wrap & (psc_q == PscMax);
  assign boundary  = step_adv & (&step_q);
  assign step_next = step_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    psc_d    = psc_q;
    step_d   = step_q;
    active_d = active_q;
    pend_d   = pend_q;
    duty_d   = duty_q;
    if (!enable) begin
      // Stopping commits any waiting request so it is not lost.
      state_d = StIdle;
      cnt_d   = '0;
      psc_d   = '0;
      step_d  = '0;
      if (state_q == StPending) begin
        active_d = pend_q;
      end else if (xfer) begin
        active_d = mode_req;
      end
      duty_d = wave(active_d, '0);
    end else if (state_q == StIdle) begin
      state_d = StRun;
      if (xfer) begin
        active_d = mode_req;
      end
      duty_d = wave(active_d, '0);
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (wrap) begin
        psc_d  = step_adv ? 8'd0 : psc_q + 8'd1;
        duty_d = wave(active_q, step_adv ? step_next : step_q);
      end
      if (step_adv) begin
        step_d = step_next;
      end
      if (state_q == StPending) begin
        if (boundary) begin
          active_d = pend_q;
          duty_d   = wave(pend_q, '0);
          state_d  = StRun;
        end
      end else if (xfer) begin
        pend_d  = mode_req;
        state_d = StPending;
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      psc_q    <= '0;
      step_q   <= '0;
      active_q <= '0;
      pend_q   <= '0;
      duty_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      psc_q    <= psc_d;
      step_q   <= step_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      duty_q   <= duty_d;
    end
  end

  assign active_mode = active_q;
  assign step_idx    = step_q;
  assign duty        = duty_q;
  assign period_tick = wrap;
  assign pulse       = enable & ({1'b0, cnt_q} < duty_q);

endmodule

// File: tb/tb_pwm_wave_sequencer.sv
// Randomised and directed bench for pwm_wave_sequencer against a time-based envelope model.
module tb_pwm_wave_sequencer;

  localparam int W    = 6;
  localparam int P    = 1;
  localparam int M    = 1 << W;
  localparam int HALF = M / 2;
  localparam int ENV  = M * P * M;

  logic         sysclk, rst_n, enable, mode_valid;
  logic [1:0]   mode_req;
  logic         mode_ready, period_tick, pulse;
  logic [1:0]   active_mode;
  logic [W-1:0] step_idx;
  logic [W:0]   duty;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: cycles since the first running cycle, plus mode bookkeeping.
  int       t;
  bit       run;
  bit       m_pend;
  logic [1:0] m_act, m_pv;

  pwm_wave_sequencer #(.CNT_W(W), .PRESCALE(P)) dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .enable     (enable),
    .mode_req   (mode_req),
    .mode_valid (mode_valid),
    .mode_ready (mode_ready),
    .active_mode(active_mode),
    .step_idx   (step_idx),
    .duty       (duty),
    .period_tick(period_tick),
    .pulse      (pulse)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  function automatic int f_ref(input logic [1:0] m, input int s);
    case (m)
      2'd1: return (s < HALF) ? M : 0;
      2'd2: return s;
      2'd3: begin
`ifdef WAVE_TRIANGLE_EN
        return (s < HALF) ? 2 * s : 2 * (M - s);
`else
        return 0;
`endif
      end
      default: return 0;
    endcase
  endfunction

  function automatic int exp_cnt();
    return run ? t % M : 0;
  endfunction

  function automatic int exp_step();
    return run ? (t / (M * P)) % M : 0;
  endfunction

  function automatic int exp_duty();
    return f_ref(m_act, exp_step());
  endfunction

  function automatic logic exp_pulse();
    return enable && (exp_cnt() < exp_duty());
  endfunction

  function automatic logic exp_tick();
    return run && (t % M == M - 1);
  endfunction

  task automatic model_reset();
    t = 0; run = 0; m_pend = 0; m_act = 2'd0; m_pv = 2'd0;
  endtask

  // Advance one clock and step the model with the inputs seen at that edge.
  task automatic tick();
    bit x, wasp;
    logic en;
    logic [1:0] rq;
    x  = mode_valid && !m_pend;
    en = enable;
    rq = mode_req;
    @(posedge sysclk);
    if (!en) begin
      if (m_pend) m_act = m_pv;
      else if (x) m_act = rq;
      m_pend = 0; run = 0; t = 0;
    end else if (!run) begin
      if (x) m_act = rq;
      run = 1; t = 0;
    end else begin
      wasp = m_pend;
      t++;
      if (wasp && (t % ENV == 0)) begin
        m_act = m_pv; m_pend = 0;
      end else if (!wasp && x) begin
        m_pend = 1; m_pv = rq;
      end
    end
    #1;
  endtask

  task automatic request_in_idle(input logic [1:0] m);
    enable = 0; tick();
    mode_valid = 1; mode_req = m; tick();
    mode_valid = 0;
    n_checks++;
    if (active_mode !== m) begin
      n_fail++; $display("FAIL idle_request: active_mode=%0d want %0d", active_mode, m);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; enable = 0; mode_valid = 0; mode_req = 0;
    model_reset();
    repeat (3) @(posedge sysclk);
    @(negedge sysclk); rst_n = 1; #1;
    n_checks += 6;
    if (active_mode !== 2'd0) begin n_fail++; $display("FAIL rst_active: %0d want 0", active_mode); end
    if (step_idx !== '0) begin n_fail++; $display("FAIL rst_step: %0d want 0", step_idx); end
    if (duty !== '0) begin n_fail++; $display("FAIL rst_duty: %0d want 0", duty); end
    if (mode_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: %b want 1", mode_ready); end
    if (period_tick !== 1'b0) begin n_fail++; $display("FAIL rst_tick: %b want 0", period_tick); end
    if (pulse !== 1'b0) begin n_fail++; $display("FAIL rst_pulse: %b want 0", pulse); end
  endtask

  task automatic test_off_run();
    enable = 1; tick();
    for (int i = 0; i < 4 * M; i++) begin
      n_checks += 3;
      if (pulse !== 1'b0) begin n_fail++; $display("FAIL off_pulse: t=%0d got %b want 0", t, pulse); end
      if (period_tick !== exp_tick()) begin
        n_fail++; $display("FAIL off_tick: t=%0d got %b want %b", t, period_tick, exp_tick());
      end
      if (int'(step_idx) != exp_step()) begin
        n_fail++; $display("FAIL off_step: t=%0d got %0d want %0d", t, step_idx, exp_step());
      end
      tick();
    end
  endtask

  task automatic test_square();
    int highs;
    request_in_idle(2'd1);
    enable = 1; tick();
    highs = 0;
    for (int i = 0; i < ENV; i++) begin
      n_checks++;
      if (pulse !== (exp_step() < HALF)) begin
        n_fail++; $display("FAIL sq_pulse: t=%0d got %b want %b", t, pulse, exp_step() < HALF);
      end
      if (pulse === 1'b1) highs++;
      tick();
    end
    n_checks++;
    if (highs != HALF * M * P) begin
      n_fail++; $display("FAIL sq_high_count: got %0d want %0d", highs, HALF * M * P);
    end
  endtask

  task automatic test_mode_change();
    bool_done: begin end
    for (int i = 0; i < ENV && exp_step() != 5; i++) tick();
    repeat (17) tick();
    mode_valid = 1; mode_req = 2'd2; tick();
    n_checks += 2;
    if (mode_ready !== 1'b0) begin n_fail++; $display("FAIL mc_ready_low: got %b want 0", mode_ready); end
    if (active_mode !== 2'd1) begin n_fail++; $display("FAIL mc_early: got %0d want 1", active_mode); end
    for (int i = 0; i <= ENV + 4; i++) begin
      mode_valid = (i < 100); mode_req = 2'd3;
      n_checks++;
      if (active_mode !== m_act) begin
        n_fail++; $display("FAIL mc_active: t=%0d got %0d want %0d", t, active_mode, m_act);
      end
      if (m_act == 2'd2) begin
        n_checks += 3;
        if (step_idx !== '0) begin n_fail++; $display("FAIL mc_at_wrap: step=%0d want 0", step_idx); end
        if (mode_ready !== 1'b1) begin n_fail++; $display("FAIL mc_ready_back: %b want 1", mode_ready); end
        if (int'(duty) != f_ref(2'd2, 0)) begin n_fail++; $display("FAIL mc_duty: %0d want 0", duty); end
        break;
      end
      if (i == ENV + 4) begin
        n_checks++; n_fail++; $display("FAIL mc_timeout: active_mode=%0d want 2", active_mode);
      end
      tick();
    end
    mode_valid = 0;
  endtask

  task automatic test_pending_disable();
    mode_valid = 1; mode_req = 2'd1; tick();
    mode_valid = 0; repeat (3) tick();
    n_checks++;
    if (mode_ready !== 1'b0) begin n_fail++; $display("FAIL pd_pending: ready=%b want 0", mode_ready); end
    enable = 0; tick();
    n_checks += 5;
    if (active_mode !== 2'd1) begin n_fail++; $display("FAIL pd_active: %0d want 1", active_mode); end
    if (step_idx !== '0) begin n_fail++; $display("FAIL pd_step: %0d want 0", step_idx); end
    if (pulse !== 1'b0) begin n_fail++; $display("FAIL pd_pulse: %b want 0", pulse); end
    if (mode_ready !== 1'b1) begin n_fail++; $display("FAIL pd_ready: %b want 1", mode_ready); end
    if (int'(duty) != M) begin n_fail++; $display("FAIL pd_duty: %0d want %0d", duty, M); end
  endtask

  task automatic test_saw();
    int highs;
    request_in_idle(2'd2);
    enable = 1; tick();
    repeat (10 * M * P) tick();
    highs = 0;
    for (int i = 0; i < M; i++) begin
      n_checks++;
      if (int'(duty) != 10) begin n_fail++; $display("FAIL saw_duty: t=%0d got %0d want 10", t, duty); end
      if (pulse === 1'b1) highs++;
      tick();
    end
    n_checks++;
    if (highs != 10) begin n_fail++; $display("FAIL saw_high_count: got %0d want 10", highs); end
  endtask

  task automatic test_triangle();
    int want_peak, want_end;
`ifdef WAVE_TRIANGLE_EN
    want_peak = M; want_end = 2;
`else
    want_peak = 0; want_end = 0;
`endif
    request_in_idle(2'd3);
    enable = 1; tick();
    for (int i = 0; i < ENV; i++) begin
      n_checks++;
      if (int'(duty) != exp_duty()) begin
        n_fail++; $display("FAIL tri_duty: t=%0d got %0d want %0d", t, duty, exp_duty());
      end
      if (exp_cnt() == 0 && exp_step() == HALF) begin
        n_checks++;
        if (int'(duty) != want_peak) begin n_fail++; $display("FAIL tri_peak: %0d want %0d", duty, want_peak); end
      end
      if (exp_cnt() == 0 && exp_step() == M - 1) begin
        n_checks++;
        if (int'(duty) != want_end) begin n_fail++; $display("FAIL tri_end: %0d want %0d", duty, want_end); end
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    request_in_idle(2'd2);
    enable = 1;
    repeat (700) tick();
    #2 rst_n = 0; enable = 0;
    #1;
    model_reset();
    n_checks += 5;
    if (step_idx !== '0) begin n_fail++; $display("FAIL ar_step: %0d want 0", step_idx); end
    if (duty !== '0) begin n_fail++; $display("FAIL ar_duty: %0d want 0", duty); end
    if (active_mode !== 2'd0) begin n_fail++; $display("FAIL ar_active: %0d want 0", active_mode); end
    if (mode_ready !== 1'b1) begin n_fail++; $display("FAIL ar_ready: %b want 1", mode_ready); end
    if (pulse !== 1'b0) begin n_fail++; $display("FAIL ar_pulse: %b want 0", pulse); end
    #2 rst_n = 1;
  endtask

  task automatic test_random();
    enable = 1;
    for (int i = 0; i < 6000; i++) begin
      n_checks += 6;
      if (active_mode !== m_act) begin n_fail++; $display("FAIL rnd_active: t=%0d got %0d want %0d", t, active_mode, m_act); end
      if (mode_ready !== !m_pend) begin n_fail++; $display("FAIL rnd_ready: t=%0d got %b want %b", t, mode_ready, !m_pend); end
      if (int'(step_idx) != exp_step()) begin n_fail++; $display("FAIL rnd_step: t=%0d got %0d want %0d", t, step_idx, exp_step()); end
      if (int'(duty) != exp_duty()) begin n_fail++; $display("FAIL rnd_duty: t=%0d got %0d want %0d", t, duty, exp_duty()); end
      if (period_tick !== exp_tick()) begin n_fail++; $display("FAIL rnd_tick: t=%0d got %b want %b", t, period_tick, exp_tick()); end
      if (pulse !== exp_pulse()) begin n_fail++; $display("FAIL rnd_pulse: t=%0d got %b want %b", t, pulse, exp_pulse()); end
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1;
      mode_valid = ($urandom_range(0, 7) == 0);
      mode_req   = 2'($urandom_range(0, 3));
      tick();
    end
    mode_valid = 0;
  endtask

  initial begin
    test_reset();
    test_off_run();
    test_square();
    test_mode_change();
    test_pending_disable();
    test_saw();
    test_triangle();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_wave_sequencer.md
# pwm_wave_sequencer

Controller that sequences a PWM carrier stage: it runs the carrier counter, steps a 64-step envelope index and loads a new duty cycle once per carrier period according to the selected waveform mode. Mode changes arrive over a valid/ready handshake and are applied only at an envelope boundary, so the output never shows a partial envelope. It sits between the switch/mode-select logic and the LED/audio pulse pin, and it is the generalised replacement for the fixed square-modulation generators.

## Interface
- CNT_W, 6: carrier counter width; envelope also has 2^CNT_W steps.
- PRESCALE, 1: carrier periods per envelope step; legal range 1..255.

- sysclk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run/stop, level-sensitive, synchronous
- mode_req  in  2  requested mode: 0 OFF, 1 SQUARE, 2 SAW, 3 TRIANGLE
- mode_valid  in  1  mode_req valid
- mode_ready  out  1  sequencer can accept a mode request
- active_mode  out  2  mode currently driving duty
- step_idx  out  CNT_W  current envelope step
- duty  out  CNT_W+1  registered duty; 2^CNT_W means 100 %
- period_tick  out  1  high for the cycle in which the carrier counter is at 2^CNT_W-1
- pulse  out  1  PWM output

## Operation
- States: IDLE (enable=0), RUN, PENDING. On reset: IDLE, cnt=0, prescale count=0, step_idx=0, active_mode=0, duty=0, mode_ready=1, period_tick=0, pulse=0.
- Carrier: cnt increments every cycle in RUN/PENDING and wraps 2^CNT_W-1 -> 0. In IDLE, cnt, step_idx and prescale count are held at 0.
- Step advance: on a wrap, the prescale count increments; at PRESCALE it clears and step_idx increments (wrapping from 2^CNT_W-1 to 0).
- Duty: loaded only on a wrap edge as f(mode, next step_idx). In IDLE, loaded every cycle with f(active_mode, 0).
- f with CNT_W=6 and M=64: OFF gives 0. SQUARE gives 64 for step<32 and 0 otherwise. SAW gives step (0..63). TRIANGLE gives 2*step for step<32 and 2*(64-step) for step>=32 (peak 64 at step 32, 2 at step 63). For general CNT_W, 32 and 64 scale to 2^(CNT_W-1) and 2^CNT_W.
- pulse = enable & (cnt < duty), compared at CNT_W+1 bits. A duty of 2^CNT_W holds pulse high for the whole period.
- Handshake: mode_ready=1 in IDLE and RUN, 0 in PENDING. A request transfers when mode_valid & mode_ready. mode_valid is ignored while mode_ready=0.
- IDLE + transfer: active_mode is updated on the next edge; the state stays IDLE.
- RUN + transfer: the request is latched as pending and the state goes to PENDING.
- PENDING: on the wrap edge that takes step_idx from 2^CNT_W-1 to 0, active_mode takes the pending value, duty takes f(pending, 0), and the state returns to RUN.
- A request equal to active_mode is still accepted and follows the same path.
- enable falling in any state: the next state is IDLE and counters clear. A pending mode is committed to active_mode on that same edge.
- enable rising: IDLE -> RUN. The first running cycle has cnt=0, step_idx=0 and duty=f(active_mode, 0).
- Reset asserted mid-operation returns everything to the reset values immediately, with no wait for a clock edge.

## Timing
- duty, step_idx and active_mode change only on a wrap edge while running. pulse is combinational from registers and enable, with no added latency.
- Carrier period is 2^CNT_W cycles. Envelope period is 2^CNT_W * PRESCALE * 2^CNT_W cycles, which is 4096 cycles at the defaults.
- Mode-change latency in RUN is between 1 cycle and one full envelope, ending at the envelope boundary.
- A request that arrives on the boundary edge itself is latched, and it waits for the next boundary.

## Configuration
- WAVE_TRIANGLE_EN defined: TRIANGLE (mode 3) is implemented as described above.
- WAVE_TRIANGLE_EN undefined: the triangle logic is removed and mode 3 is still accepted and reported on active_mode, but f returns 0 (it behaves as OFF).

## Test plan
- Reset, then enable=1 with mode 0: pulse stays 0, period_tick pulses every 64 cycles, and step_idx increments every 64 cycles.
- In IDLE, apply mode 1, then set enable=1: pulse is high for steps 0..31 (2048 cycles) and low for steps 32..63.
- Mode 2, step_idx=10: pulse is high for exactly 10 cycles of the 64-cycle period.
- Running in mode 1, request mode 2 at step 5: mode_ready goes low, and active_mode changes to 2 exactly when step_idx wraps 63 -> 0.
- Request pending, then drop enable: the state goes to IDLE, active_mode equals the pending mode, and cnt, step_idx and pulse are 0.
- Mode 3 with WAVE_TRIANGLE_EN: duty is 64 at step 32 and 2 at step 63. Without WAVE_TRIANGLE_EN, duty is 0 throughout.
